// File: rtl/serial_alu_pkg.sv
// Shared types for the bit-serial ALU sequencer: opcode encodings, FSM state and opcode helpers.
// Optional build macro SERIAL_ALU_OVF_EN (used in serial_alu_seq) adds a signed-overflow output.
package serial_alu_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_ADD  = 3'b000;
  localparam opcode_t OP_SUB  = 3'b001;
  localparam opcode_t OP_AND  = 3'b010;
  localparam opcode_t OP_OR   = 3'b011;
  localparam opcode_t OP_NAND = 3'b100;
  localparam opcode_t OP_NOR  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_arith(input opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // 110 and 111 are the only unassigned encodings
  function automatic logic is_illegal(input opcode_t op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/serial_alu_seq_bit_slice.sv
// Combinational 1-bit ALU slice; the caller pre-inverts b for subtraction and owns the carry chain.
// Unaffected by SERIAL_ALU_OVF_EN.
module alu_bit_slice
  import serial_alu_pkg::*;
(
  input  opcode_t opcode,
  input  logic    a,
  input  logic    b,
  input  logic    cin,
  output logic    res,
  output logic    cout
);

  always_comb begin
    res  = 1'b0;
    cout = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB: begin
        res  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      default: res = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: feeds one operand bit per cycle (LSB first) through alu_bit_slice.
// Define SERIAL_ALU_OVF_EN to add the ovf_flag output (signed overflow for ADD/SUB).
module serial_alu_seq
  import serial_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             carry_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero_flag,
  output logic             gt_flag,
  output logic             bad_op
`ifdef SERIAL_ALU_OVF_EN
  ,
  output logic             ovf_flag
`endif
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  opcode_t          op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] res_sh;
  logic             zero_acc;
  logic             gt_acc;
  logic             ovf_r;

  logic             a_bit;
  logic             b_raw;
  logic             b_bit;
  logic             slice_res;
  logic             slice_cout;
  logic             gt_next;
  logic             last_bit;
  logic             arith;
  logic             illegal;
  logic             accept;

  assign arith    = is_arith(op_r);
  assign illegal  = is_illegal(op_r);
  assign accept   = op_valid & op_ready;
  assign last_bit = (idx == LAST_IDX);

  assign a_bit   = a_r[idx];
  assign b_raw   = b_r[idx];
  assign b_bit   = (op_r == OP_SUB) ? ~b_raw : b_raw;
  // Unsigned compare runs LSB first, so the highest differing bit seen so far wins
  assign gt_next = (a_bit ^ b_raw) ? a_bit : gt_acc;

  alu_bit_slice u_slice (
    .opcode (op_r),
    .a      (a_bit),
    .b      (b_bit),
    .cin    (carry_r),
    .res    (slice_res),
    .cout   (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (op_valid) state_next = BUSY;
      BUSY:    if (last_bit) state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    op_ready  = (state == IDLE);
    res_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_r      <= OP_ADD;
      a_r       <= '0;
      b_r       <= '0;
      carry_r   <= 1'b0;
      idx       <= '0;
      res_sh    <= '0;
      zero_acc  <= 1'b0;
      gt_acc    <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      zero_flag <= 1'b0;
      gt_flag   <= 1'b0;
      bad_op    <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_r      <= opcode;
            a_r       <= operand_a;
            b_r       <= operand_b;
            carry_r   <= (opcode == OP_ADD) ? carry_in : (opcode == OP_SUB);
            idx       <= '0;
            res_sh    <= '0;
            zero_acc  <= 1'b1;
            gt_acc    <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero_flag <= 1'b0;
            gt_flag   <= 1'b0;
            bad_op    <= 1'b0;
            ovf_r     <= 1'b0;
          end
        end
        BUSY: begin
          res_sh   <= {slice_res, res_sh[WIDTH-1:1]};
          zero_acc <= zero_acc & ~slice_res;
          gt_acc   <= gt_next;
          if (arith) carry_r <= slice_cout;
          idx <= last_bit ? '0 : idx + IW'(1);
          // Visible outputs are only touched once the final bit has been through the slice
          if (last_bit) begin
            result    <= illegal ? '0 : {slice_res, res_sh[WIDTH-1:1]};
            carry_out <= arith & slice_cout;
            zero_flag <= illegal | (zero_acc & ~slice_res);
            gt_flag   <= gt_next;
            bad_op    <= illegal;
            ovf_r     <= arith & (carry_r ^ slice_cout);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ALU_OVF_EN
  assign ovf_flag = ovf_r;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_r;
`endif

endmodule

// File: doc/serial_alu_seq.md
Name: serial_alu_seq

Overview:
- Multi-bit, bit-serial ALU sequencer that drives the team's 1-bit ALU opcode interface from the other side: it accepts an N-bit operation, feeds one bit per cycle (LSB first) through a 1-bit ALU slice, and chains the carry between cycles.
- It assembles the N-bit result plus the Zero and Greater flags and returns them over a valid/ready handshake.
- It sits between a controller and the 1-bit ALU datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset; the only reset in the block.
- op_valid  input  1  request valid.
- op_ready  output  1  block can accept a request.
- opcode  input  3  operation: ADD=000, SUB=001, AND=010, OR=011, NAND=100, NOR=101.
- operand_a  input  WIDTH  first input.
- operand_b  input  WIDTH  second input.
- carry_in  input  1  initial carry for ADD; ignored for SUB (forced 1) and for logic ops.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer accepts result.
- result  output  WIDTH  operation result.
- carry_out  output  1  final carry (ADD/SUB, 1 = no borrow on SUB); 0 for logic ops.
- zero_flag  output  1  result == 0.
- gt_flag  output  1  operand_a > operand_b, unsigned.
- bad_op  output  1  opcode was 110 or 111.

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset: state=IDLE; op_ready=1; res_valid=0; result=0; carry_out=0; zero_flag=0; gt_flag=0; bad_op=0; bit index=0.
- IDLE:
  - op_ready=1. On op_valid&op_ready, latch opcode and operands; carry register = carry_in (ADD), 1 (SUB), 0 (others).
  - Clear the result shift register, gt accumulator=0, zero accumulator=1, index=0. Go to BUSY.
- BUSY:
  - op_ready=0. Each cycle processes bit index i: a_i, b_i (inverted for SUB), and the carry register go to the slice.
  - The slice result bit shifts into result[i]; the carry register takes the slice carry (arithmetic ops only).
  - zero acc &= ~res_i; gt acc = (a_i^b_i) ? a_i : gt acc (unmodified b used for gt).
  - After i=WIDTH-1, go to DONE. Exactly WIDTH cycles in BUSY.
- DONE:
  - res_valid=1; outputs stable until res_ready. On res_valid&res_ready, go to IDLE.
  - Accept-to-valid latency = WIDTH+1 cycles. No new request is accepted in the same cycle as result handoff.
- Illegal opcode (110/111):
  - Still takes WIDTH cycles; result=0, carry_out=0, zero_flag=1, bad_op=1.
  - gt_flag is still computed normally.
- Wrap-around: ADD/SUB are modulo 2^WIDTH; carry_out reports the overflow.
- Outputs change only on IDLE->BUSY (clear) and BUSY->DONE (final update); they hold through DONE and IDLE.
- Reset asserted in any state, including mid-BUSY: next cycle is IDLE with reset values. The partial operation is discarded with no res_valid pulse.
- op_valid while not in IDLE is ignored; operand inputs are don't-care outside the accept cycle.

Optional Feature:
- Macro: SERIAL_ALU_OVF_EN.
- Defined: adds output ovf_flag (1 bit), the signed two's-complement overflow for ADD/SUB. It equals the carry into the MSB XOR the carry out of the MSB, captured at i=WIDTH-1. It is 0 for logic and illegal ops and 0 at reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_alu_pkg:
  - opcode localparams OP_ADD..OP_NOR.
  - FSM state enum (IDLE/BUSY/DONE).
  - 3-bit opcode type.
- Sub-module alu_bit_slice: combinational 1-bit ALU (opcode, a, b, cin -> res, cout). It is instantiated once and reused every cycle; the sequencer owns all state.

Test Plan:
- WIDTH=8, ADD a=0x3C, b=0x05, carry_in=0: result=0x41, carry_out=0, zero=0, gt=1, res_valid rises 9 cycles after accept.
- SUB a=0x05, b=0x05: result=0x00, carry_out=1, zero=1, gt=0. Then SUB a=0x03, b=0x07: result=0xFC, carry_out=0, gt=0.
- ADD a=0xFF, b=0x01, carry_in=1: result=0x01, carry_out=1 (wrap). With SERIAL_ALU_OVF_EN, ADD 0x7F+0x01: result=0x80, ovf_flag=1.
- Logic ops with a=0xF0, b=0xCC: AND=0xC0, OR=0xFC, NAND=0x3F, NOR=0x03, carry_out=0. Opcode 110: result=0, zero=1, bad_op=1.
- Backpressure: hold res_ready=0 for 5 cycles in DONE; outputs stable, op_ready=0, a new op_valid is ignored. Release: handoff, then IDLE, op_ready=1.
- Reset asserted at BUSY bit 3: next cycle IDLE with all outputs at reset values, no res_valid. A following ADD completes correctly.
